// File: rtl/coloring_fb.sv
// Frame-buffer colouring stage: paints per-triangle visible-pixel streams into on-chip
// memory, then streams the finished frame out as packed 32-bit words and clears it.
module coloring_fb #(
   parameter int X_BITS   = 8,
   parameter int Y_BITS   = 8,
   parameter int NUM_TRI  = 3192,
   parameter int CNT_BITS = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Input_1_V_TDATA,
   input  logic        Input_1_V_TVALID,
   output logic        Input_1_V_TREADY,
   output logic [31:0] Output_1_V_TDATA,
   output logic        Output_1_V_TVALID,
   input  logic        Output_1_V_TREADY,
   output logic        frame_done
);
   localparam int ADDR_BITS = X_BITS + Y_BITS - 2;
   localparam int W         = 1 << ADDR_BITS;
   localparam int TRI_BITS  = (NUM_TRI > 1) ? $clog2(NUM_TRI) : 1;
   localparam logic [TRI_BITS-1:0]  LAST_TRI = TRI_BITS'(NUM_TRI - 1);
   localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);
   localparam logic [CNT_BITS-1:0]  CNT_ONE  = CNT_BITS'(1);
   localparam logic [TRI_BITS-1:0]  TRI_ONE  = TRI_BITS'(1);

   typedef enum logic [1:0] {S_CLEAR, S_COUNT, S_PIXEL, S_DUMP} state_t;

   state_t                state_q;
   logic [ADDR_BITS-1:0]  clr_addr_q;
   logic [TRI_BITS-1:0]   tri_q;
   logic [CNT_BITS-1:0]   pix_left_q;
   logic                  in_rdy_q;
   logic                  pend_vld_q;
   logic [ADDR_BITS-1:0]  pend_word_q;
   logic [1:0]            pend_lane_q;
   logic [7:0]            pend_color_q;
   logic [ADDR_BITS-1:0]  rd_addr_q;
   logic                  rd_all_q;
   logic                  dump_run_q;
   logic [ADDR_BITS-1:0]  out_cnt_q;
   logic                  vld_p1_q;
   logic [31:0]           rd_p1_q;
   logic [31:0]           skid_q [2];
   logic                  skid_wp_q;
   logic                  skid_rp_q;
   logic [1:0]            skid_cnt_q;
   logic [31:0]           mem_q [W];

   logic                  in_acc;
   logic                  tri_end;
   logic [CNT_BITS-1:0]   cnt_field;
   logic [X_BITS+Y_BITS-1:0] pix_addr;
   logic                  pop;
   logic                  head_from_rd;
   logic                  push;
   logic                  pop_skid;
   logic [1:0]            occ;
   logic                  rd_en;
   logic [3:0]            wr_be;
   logic [ADDR_BITS-1:0]  wr_addr;
   logic [31:0]           wr_data;
   logic                  unused_bits;

   assign unused_bits      = ^Input_1_V_TDATA[31:24];
   assign Input_1_V_TREADY = in_rdy_q;
   assign in_acc           = Input_1_V_TVALID & in_rdy_q;
   assign cnt_field        = Input_1_V_TDATA[CNT_BITS-1:0];
   assign pix_addr         = {Input_1_V_TDATA[8 +: Y_BITS], Input_1_V_TDATA[0 +: X_BITS]};
   assign tri_end          = in_acc & (((state_q == S_COUNT) & (cnt_field == '0)) |
                                       ((state_q == S_PIXEL) & (pix_left_q == CNT_ONE)));

   // Output side: the RAM read register is presented directly while the skid buffer is
   // empty, so data read in cycle t is visible in t+1 and throughput is one word per cycle.
   assign head_from_rd      = (skid_cnt_q == 2'd0);
   assign Output_1_V_TVALID = vld_p1_q | ~head_from_rd;
   assign Output_1_V_TDATA  = head_from_rd ? rd_p1_q : skid_q[skid_rp_q];
   assign pop               = Output_1_V_TVALID & Output_1_V_TREADY;
   assign push              = vld_p1_q & ~(head_from_rd & pop);
   assign pop_skid          = pop & ~head_from_rd;
   assign occ               = skid_cnt_q + {1'b0, vld_p1_q};
   assign rd_en             = (state_q == S_DUMP) & dump_run_q & ~rd_all_q &
                              (occ <= ({1'b0, pop} + 2'd1));
   assign frame_done        = pop & (out_cnt_q == '1);

   // Single write port; pixel writes never coincide with clear or dump zeroing because
   // the dump holds off its first read for one cycle to let the final pixel land.
   always_comb begin
      wr_be   = 4'b0000;
      wr_addr = clr_addr_q;
      wr_data = 32'd0;
      if (pend_vld_q) begin
         wr_be   = 4'b0001 << pend_lane_q;
         wr_addr = pend_word_q;
         wr_data = {4{pend_color_q}};
      end else if (state_q == S_CLEAR) begin
         wr_be = 4'b1111;
      end else if (rd_en) begin
         wr_be   = 4'b1111;
         wr_addr = rd_addr_q;
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (wr_be[k]) mem_q[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
      end
      if (rd_en) rd_p1_q <= mem_q[rd_addr_q];
   end

   always_ff @(posedge clk) begin
      if (in_acc && state_q == S_PIXEL) begin
         pend_word_q  <= pix_addr[X_BITS+Y_BITS-1:2];
         pend_lane_q  <= pix_addr[1:0];
         pend_color_q <= Input_1_V_TDATA[23:16];
      end
      if (push) skid_q[skid_wp_q] <= rd_p1_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1_q   <= 1'b0;
         skid_wp_q  <= 1'b0;
         skid_rp_q  <= 1'b0;
         skid_cnt_q <= 2'd0;
      end else begin
         vld_p1_q <= rd_en;
         if (push)     skid_wp_q <= ~skid_wp_q;
         if (pop_skid) skid_rp_q <= ~skid_rp_q;
         skid_cnt_q <= skid_cnt_q + {1'b0, push} - {1'b0, pop_skid};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_CLEAR;
         clr_addr_q <= '0;
         tri_q      <= '0;
         pix_left_q <= '0;
         in_rdy_q   <= 1'b0;
         pend_vld_q <= 1'b0;
         rd_addr_q  <= '0;
         rd_all_q   <= 1'b0;
         dump_run_q <= 1'b0;
         out_cnt_q  <= '0;
      end else begin
         pend_vld_q <= 1'b0;
         unique case (state_q)
            S_CLEAR: begin
               clr_addr_q <= clr_addr_q + ADDR_ONE;
               if (clr_addr_q == '1) begin
                  state_q  <= S_COUNT;
                  in_rdy_q <= 1'b1;
               end
            end
            S_COUNT: begin
               if (in_acc && cnt_field != '0) begin
                  pix_left_q <= cnt_field;
                  state_q    <= S_PIXEL;
               end
            end
            S_PIXEL: begin
               if (in_acc) begin
                  pend_vld_q <= 1'b1;
                  pix_left_q <= pix_left_q - CNT_ONE;
                  if (pix_left_q == CNT_ONE) state_q <= S_COUNT;
               end
            end
            S_DUMP: begin
               dump_run_q <= 1'b1;
               if (rd_en) begin
                  rd_addr_q <= rd_addr_q + ADDR_ONE;
                  if (rd_addr_q == '1) rd_all_q <= 1'b1;
               end
               if (pop) begin
                  out_cnt_q <= out_cnt_q + ADDR_ONE;
                  if (out_cnt_q == '1) begin
                     state_q  <= S_COUNT;
                     in_rdy_q <= 1'b1;
                  end
               end
            end
         endcase
         if (tri_end) begin
            if (tri_q == LAST_TRI) begin
               tri_q      <= '0;
               state_q    <= S_DUMP;
               in_rdy_q   <= 1'b0;
               rd_addr_q  <= '0;
               rd_all_q   <= 1'b0;
               dump_run_q <= 1'b0;
               out_cnt_q  <= '0;
            end else begin
               tri_q <= tri_q + TRI_ONE;
            end
         end
      end
   end
endmodule
